wb_port_arbiter: RTL
====================

# wb_port_arbiter

Arbitrates the single register-file write port between the in-order pipeline writeback (the `wb_data` output of the WB mux) and a long-latency multiply/divide unit (MDU). Pipeline writes have priority. MDU results are buffered in a small FIFO and drained into free write slots. A starvation counter forces a one-cycle pipeline stall so a buffered MDU result can never wait indefinitely. The block sits between WB and the register file and exports a pending-destination mask to the hazard unit.

## Interface
- `XLEN`, 32, data width
- `DEPTH`, 2, MDU result FIFO entries (power of two, ≥2)
- `STARVE_LIMIT`, 4, maximum consecutive non-drain cycles for a buffered MDU entry (≥1)

Ports:
- `clk` in 1: single clock, all state updates on rising edge
- `rst` in 1: reset, synchronous, active-high
- `pipe_valid` in 1: pipeline WB slot carries a register write
- `pipe_rd` in 5: pipeline destination register
- `pipe_data` in XLEN: pipeline writeback data (WB mux output)
- `pipe_stall` out 1: registered; pipeline must hold its WB inputs this cycle
- `mdu_valid` in 1: MDU result available
- `mdu_rd` in 5: MDU destination register
- `mdu_data` in XLEN: MDU result
- `mdu_ready` out 1: FIFO can accept; transfer when `mdu_valid && mdu_ready`
- `rf_we` out 1: registered register-file write enable
- `rf_waddr` out 5: registered write address
- `rf_wdata` out XLEN: registered write data
- `pending_mask` out 32: bit r set while any FIFO entry targets xr

## Operation
- Each cycle selects at most one write source:
  - **Stall cycle** (`pipe_stall`=1): pipeline inputs are ignored. FIFO head is popped and written.
  - **Otherwise, pipeline active** (`pipe_valid`=1, `pipe_rd`≠0): pipeline is written. FIFO is not popped.
  - **Otherwise, FIFO non-empty**: head is popped and written. A pipeline x0 write or an idle slot counts as a free slot.
  - **Otherwise**: no write.
- x0 is never written: `rf_we` stays 0 for `rd`=0 from either source.
- MDU handshake with `mdu_rd`=0 is accepted and discarded; nothing is enqueued.
- Push and pop may occur in the same cycle. Count changes by push−pop.
- `mdu_ready` = !full, derived from registered count. It is 0 while `rst`=1.
- A push is never written in its own cycle; there is no bypass. The entry is eligible for pop from the next cycle.
- `pending_mask` is the OR of the one-hot decoded `rd` of all valid entries. It is combinational from FIFO state.
  - Duplicate `rd` entries keep the bit set until the last one drains.
- Starvation counter `starve_cnt`:
  - Clears on any pop or when the FIFO is empty.
  - Otherwise increments each cycle.
  - If `starve_cnt == STARVE_LIMIT-1` and no pop occurs this cycle, `pipe_stall` is set for the next cycle.
- `pipe_stall` is a one-cycle pulse. The stall cycle always pops, which clears the counter.
- Ordering between a pipeline write and a FIFO entry with the same `rd` is the hazard unit's responsibility, using `pending_mask`.

## Timing
- Reset values:
  - `rf_we`=0, `rf_waddr`=0, `rf_wdata`=0
  - `pipe_stall`=0
  - `pending_mask`=0
  - FIFO empty, `starve_cnt`=0
  - `mdu_ready`=1 from the first cycle after `rst` deasserts
- Latency:
  - Pipeline input in cycle t → `rf_*` valid in t+1.
  - MDU push in t → earliest pop in t+1 → `rf_*` valid in t+2.
  - `pending_mask` bit set in t+1, cleared in t+2 when that entry is popped in t+1.
- Worst-case wait: a head entry under continuous pipeline writes sees exactly STARVE_LIMIT non-pop cycles. It is popped in the following (stall) cycle.
- Full FIFO: `mdu_ready`=0. The MDU holds its valid/data. There is no same-cycle pop-and-push when full.
- Reset mid-operation: all FIFO entries are discarded and no pending `rf` write completes. Outputs hold reset values in the cycle after `rst`.
- Pointers wrap modulo DEPTH. Full and empty are distinguished by the count register.

## Test plan
1. **Reset**: assert `rst` 2 cycles → `rf_we`=0, `pipe_stall`=0, `pending_mask`=0. The cycle after release, `mdu_ready`=1.
2. **Pipeline write**: `pipe_valid`=1, `pipe_rd`=5, `pipe_data`=0x12345678 → next cycle `rf_we`=1, `rf_waddr`=5, `rf_wdata`=0x12345678. Repeat with `pipe_rd`=0 → `rf_we`=0.
3. **Idle drain**: pipeline idle, MDU push in t with `rd`=7, data 0xAAAAAAAA → `pending_mask`=0x80 in t+1. In t+2, `rf_we`=1, `rf_waddr`=7, `rf_wdata`=0xAAAAAAAA and `pending_mask`=0.
4. **Backpressure**: continuous pipeline writes to x3, MDU pushes `rd`=8 then `rd`=9 → `mdu_ready`=0 after the second push. The third MDU result is held until a pop occurs. No MDU data is lost or duplicated.
5. **Starvation**: STARVE_LIMIT=4, continuous pipeline writes, one MDU entry pushed in t0 → `pipe_stall`=1 only in t5. In t6, `rf_*` shows the MDU entry. The pipeline value presented in t5 is not written; when re-presented in t6, it is written in t7.
6. **Reset mid-operation**: FIFO holding 2 entries, `rst` for 1 cycle → no subsequent `rf_we` for those entries, `pending_mask`=0, `mdu_ready`=1.

Source files
------------

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter. Pipeline writeback has priority. MDU results
// queue in a small FIFO and drain into free slots, with a forced stall bounding their wait.
module wb_port_arbiter #(
    parameter int unsigned XLEN         = 32,
    parameter int unsigned DEPTH        = 2,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            pipe_valid,
    input  logic [4:0]      pipe_rd,
    input  logic [XLEN-1:0] pipe_data,
    output logic            pipe_stall,
    input  logic            mdu_valid,
    input  logic [4:0]      mdu_rd,
    input  logic [XLEN-1:0] mdu_data,
    output logic            mdu_ready,
    output logic            rf_we,
    output logic [4:0]      rf_waddr,
    output logic [XLEN-1:0] rf_wdata,
    output logic [31:0]     pending_mask
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);

    logic [4:0]      r_rd   [DEPTH];
    logic [XLEN-1:0] r_data [DEPTH];
    logic [DEPTH-1:0] r_vld;
    logic [AW-1:0]   r_wptr;
    logic [AW-1:0]   r_rptr;
    logic [CW-1:0]   r_count;
    logic [SW-1:0]   r_starve;
    logic            r_stall;
    logic            r_we;
    logic [4:0]      r_waddr;
    logic [XLEN-1:0] r_wdata;

    logic w_empty;
    logic w_full;
    logic w_push;
    logic w_pipe_sel;
    logic w_pop;
    logic w_stall_nxt;

    assign w_empty     = (r_count == CW'(0));
    assign w_full      = (r_count == CW'(DEPTH));
    assign mdu_ready   = !rst && !w_full;
    // rd=0 results are accepted but never stored
    assign w_push      = mdu_valid && mdu_ready && (mdu_rd != 5'd0);
    assign w_pipe_sel  = !r_stall && pipe_valid && (pipe_rd != 5'd0);
    assign w_pop       = !w_empty && !w_pipe_sel;
    assign w_stall_nxt = !w_empty && !w_pop && (r_starve == SW'(STARVE_LIMIT - 1));

    assign pipe_stall = r_stall;
    assign rf_we      = r_we;
    assign rf_waddr   = r_waddr;
    assign rf_wdata   = r_wdata;

    // FIFO payload storage; validity is tracked separately so no reset needed
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_rd[r_wptr]   <= mdu_rd;
            r_data[r_wptr] <= mdu_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld    <= '0;
            r_wptr   <= '0;
            r_rptr   <= '0;
            r_count  <= '0;
            r_starve <= '0;
            r_stall  <= 1'b0;
            r_we     <= 1'b0;
            r_waddr  <= '0;
            r_wdata  <= '0;
        end else begin
            if (w_pop) begin
                r_vld[r_rptr] <= 1'b0;
                r_rptr        <= r_rptr + AW'(1);
            end
            if (w_push) begin
                r_vld[r_wptr] <= 1'b1;
                r_wptr        <= r_wptr + AW'(1);
            end
            r_count <= r_count + CW'(w_push) - CW'(w_pop);

            if (w_empty || w_pop) begin
                r_starve <= '0;
            end else if (r_starve != SW'(STARVE_LIMIT)) begin
                r_starve <= r_starve + SW'(1);
            end
            r_stall <= w_stall_nxt;

            if (w_pop) begin
                r_we    <= 1'b1;
                r_waddr <= r_rd[r_rptr];
                r_wdata <= r_data[r_rptr];
            end else if (w_pipe_sel) begin
                r_we    <= 1'b1;
                r_waddr <= pipe_rd;
                r_wdata <= pipe_data;
            end else begin
                r_we    <= 1'b0;
            end
        end
    end

    // Hazard-unit view: every register still owed a write by a queued MDU result
    always_comb begin
        pending_mask = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (r_vld[i]) begin
                pending_mask[r_rd[i]] = 1'b1;
            end
        end
    end

endmodule
